// File: rtl/act_sparse_encoder_pkg.sv
// Shared widths and FSM encoding for the sparse activation write path.
// The read side imports the same package so that both agree on the row format.
package act_sparse_encoder_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int IF_WIDTH        = 16;
    localparam int ADDR_WIDTH      = 3;
    localparam int ACT_INDEX_WIDTH = $clog2(IF_WIDTH);

    typedef logic [IF_WIDTH-1:0][DATA_WIDTH-1:0] row_t;

    typedef enum logic [1:0] {
        ENC_IDLE   = 2'd0,
        ENC_GATHER = 2'd1,
        ENC_FULL   = 2'd2
    } enc_state_e;

endpackage

// File: rtl/act_sparse_encoder_if.sv
// Activation stream in, flag/data RAM write beat out.
// Handshake: an element moves on a rising clk edge where in_valid && in_ready; the RAM side has no ready.
interface act_sparse_encoder_if;
    import act_sparse_encoder_pkg::*;

    logic                           start;
    logic                           in_valid;
    logic                           in_ready;
    logic [DATA_WIDTH-1:0]          act_in;
    logic                           in_last;
    logic                           wr_req_act_flag;
    logic [IF_WIDTH-1:0]            wr_data_act_flag;
    logic [IF_WIDTH-1:0]            wr_req_act;
    logic [DATA_WIDTH*IF_WIDTH-1:0] wr_data_act;
    logic [ACT_INDEX_WIDTH:0]       row_val_num;
    logic [ADDR_WIDTH:0]            row_cnt;
    logic                           frame_done;
    logic                           full;

    modport master (
        output start, in_valid, act_in, in_last,
        input  in_ready, wr_req_act_flag, wr_data_act_flag, wr_req_act, wr_data_act,
        input  row_val_num, row_cnt, frame_done, full
    );

    modport slave (
        input  start, in_valid, act_in, in_last,
        output in_ready, wr_req_act_flag, wr_data_act_flag, wr_req_act, wr_data_act,
        output row_val_num, row_cnt, frame_done, full
    );

endinterface

// File: rtl/act_sparse_encoder_popcount16.sv
// Combinational population count of a 16-bit row bitmap.
module popcount16 (
    input  logic [15:0] bits_i,
    output logic [4:0]  count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < 16; i++) begin
            count_o = count_o + 5'(bits_i[i]);
        end
    end

endmodule

// File: rtl/act_sparse_encoder.sv
// Gathers IF_WIDTH activations per row and emits one registered write beat per row:
// the nonzero bitmap to the flag RAM plus per-column strobes for the nonzero values.
module act_sparse_encoder
    import act_sparse_encoder_pkg::*;
#(
    parameter int ROW_DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    act_sparse_encoder_if.slave  bus,
    output enc_state_e           dbg_state_o
);

    localparam logic [ADDR_WIDTH:0] ROW_DEPTH_C = (ADDR_WIDTH+1)'(ROW_DEPTH);

    enc_state_e                 state_q, state_d;
    logic [ACT_INDEX_WIDTH-1:0] col_cnt_q;
    row_t                       row_q, row_d;
    logic [IF_WIDTH-1:0]        flag_q, flag_d;
    logic [ADDR_WIDTH:0]        row_cnt_q;

    logic                       beat_q;
    logic [IF_WIDTH-1:0]        beat_flag_q;
    row_t                       beat_row_q;
    logic [ACT_INDEX_WIDTH:0]   beat_num_q;
    logic                       done_q;

    logic                       in_ready;
    logic                       accept;
    logic                       close;
    logic [ACT_INDEX_WIDTH:0]   pop_num;

    // Row as it will look after this cycle's accept; a closing row is taken from here.
    always_comb begin
        in_ready = (state_q == ENC_GATHER) && !bus.start;
        accept   = bus.in_valid && in_ready;
        close    = accept && ((col_cnt_q == ACT_INDEX_WIDTH'(IF_WIDTH-1)) || bus.in_last);
        row_d    = row_q;
        flag_d   = flag_q;
        if (accept) begin
            row_d[col_cnt_q]  = bus.act_in;
            flag_d[col_cnt_q] = (bus.act_in != '0);
        end
    end

    popcount16 u_popcount (
        .bits_i  (flag_d),
        .count_o (pop_num)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ENC_IDLE: begin
                state_d = ENC_IDLE;
            end
            ENC_GATHER: begin
                if (close) begin
                    if (bus.in_last) begin
                        state_d = ENC_IDLE;
                    end else if (row_cnt_q + 1'b1 == ROW_DEPTH_C) begin
                        state_d = ENC_FULL;
                    end
                end
            end
            ENC_FULL: begin
                state_d = ENC_FULL;
            end
            default: begin
                state_d = ENC_IDLE;
            end
        endcase
        if (bus.start) begin
            state_d = ENC_GATHER;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ENC_IDLE;
            col_cnt_q <= '0;
            row_q     <= '0;
            flag_q    <= '0;
            row_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            // Gather registers are cleared on close so unfilled columns of a short row read as 0.
            if (bus.start || close) begin
                col_cnt_q <= '0;
                row_q     <= '0;
                flag_q    <= '0;
            end else if (accept) begin
                col_cnt_q <= col_cnt_q + 1'b1;
                row_q     <= row_d;
                flag_q    <= flag_d;
            end
            if (bus.start) begin
                row_cnt_q <= '0;
            end else if (close) begin
                row_cnt_q <= row_cnt_q + 1'b1;
            end
        end
    end

    // Output beat registers are separate from gather, so a new row can start during the beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q      <= 1'b0;
            beat_flag_q <= '0;
            beat_row_q  <= '0;
            beat_num_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            beat_q      <= close;
            beat_flag_q <= close ? flag_d : '0;
            beat_row_q  <= close ? row_d : '0;
            beat_num_q  <= close ? pop_num : '0;
            done_q      <= close && bus.in_last;
        end
    end

    assign bus.in_ready         = in_ready;
    assign bus.wr_req_act_flag  = beat_q;
    assign bus.wr_data_act_flag = beat_flag_q;
    assign bus.wr_req_act       = beat_flag_q;
    assign bus.wr_data_act      = beat_row_q;
    assign bus.row_val_num      = beat_num_q;
    assign bus.row_cnt          = row_cnt_q;
    assign bus.frame_done       = done_q;
    assign bus.full             = (row_cnt_q == ROW_DEPTH_C);
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_act_sparse_encoder.sv
// Directed bench for act_sparse_encoder: drivers push expected beats, a negedge monitor pops and compares.
module tb_act_sparse_encoder;
    import act_sparse_encoder_pkg::*;

    localparam int ROW_DEPTH = 1 << ADDR_WIDTH;
    localparam int DW        = DATA_WIDTH * IF_WIDTH;

    typedef struct packed {
        logic [IF_WIDTH-1:0]      flag;
        logic [DW-1:0]            data;
        logic [ACT_INDEX_WIDTH:0] num;
        logic [ADDR_WIDTH:0]      rc;
        logic                     done;
    } beat_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    enc_state_e dbg_state;
    beat_t      exp_q[$];
    beat_t      mon_got, mon_exp;
    int         checks = 0;
    int         errors = 0;

    act_sparse_encoder_if bus();

    act_sparse_encoder #(.ROW_DEPTH(ROW_DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [IF_WIDTH-1:0] flag, input logic [DW-1:0] data,
                             input int num, input int rc, input logic done);
        beat_t b;
        b.flag = flag;
        b.data = data;
        b.num  = (ACT_INDEX_WIDTH+1)'(num);
        b.rc   = (ADDR_WIDTH+1)'(rc);
        b.done = done;
        exp_q.push_back(b);
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] v, input logic last, input int budget, output bit ok);
        bus.in_valid = 1'b1;
        bus.act_in   = v;
        bus.in_last  = last;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.act_in   = '0;
    endtask

    task automatic send_chk(input logic [7:0] v, input logic last);
        bit ok;
        send(v, last, 20, ok);
        check("accept", 32'(ok), 32'd1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            if (bus.wr_req_act_flag) begin
                mon_got.flag = bus.wr_data_act_flag;
                mon_got.data = bus.wr_data_act;
                mon_got.num  = bus.row_val_num;
                mon_got.rc   = bus.row_cnt;
                mon_got.done = bus.frame_done;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got flag=%h rc=%0d, expected no beat",
                             mon_got.flag, mon_got.rc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp || bus.wr_req_act !== mon_exp.flag) begin
                        errors++;
                        $display("FAIL beat: got flag=%h req=%h num=%0d rc=%0d done=%0b data=%h, expected flag=%h num=%0d rc=%0d done=%0b data=%h",
                                 mon_got.flag, bus.wr_req_act, mon_got.num, mon_got.rc, mon_got.done, mon_got.data,
                                 mon_exp.flag, mon_exp.num, mon_exp.rc, mon_exp.done, mon_exp.data);
                    end
                end
            end else begin
                checks++;
                if (bus.wr_req_act !== '0 || bus.frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_strobes: got req=%h done=%0b expected 0 0",
                             bus.wr_req_act, bus.frame_done);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d;
        logic [7:0]    v;
        bit            ok;

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.act_in   = '0;
        bus.in_last  = 1'b0;

        repeat (2) tick();
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_flag_strobe", 32'(bus.wr_req_act_flag), 0);
        check("rst_row_cnt", 32'(bus.row_cnt), 0);
        check("rst_full", 32'(bus.full), 0);
        check("rst_state", 32'(dbg_state), 32'(ENC_IDLE));
        reset = 1'b1;
        tick();
        check("idle_in_ready", 32'(bus.in_ready), 0);

        // Dense row 1..16
        pulse_start();
        d = '0;
        for (int c = 0; c < 16; c++) d[8*c +: 8] = 8'(c + 1);
        push_beat(16'hFFFF, d, 16, 1, 1'b0);
        for (int c = 0; c < 16; c++) send_chk(8'(c + 1), 1'b0);
        check("dense_latency", 32'(bus.wr_req_act_flag), 1);
        check("dense_row_cnt", 32'(bus.row_cnt), 1);
        check("dense_ready_in_beat", 32'(bus.in_ready), 1);

        // Sparse row: 7 @ col0, 9 @ col5, 3 @ col15
        pulse_start();
        d = '0;
        d[7:0]     = 8'd7;
        d[47:40]   = 8'd9;
        d[127:120] = 8'd3;
        push_beat(16'h8021, d, 3, 1, 1'b0);
        for (int c = 0; c < 16; c++) begin
            v = (c == 0) ? 8'd7 : (c == 5) ? 8'd9 : (c == 15) ? 8'd3 : 8'd0;
            send_chk(v, 1'b0);
        end

        // Partial last row: 20 values, last on the 20th
        pulse_start();
        d = '0;
        for (int c = 0; c < 16; c++) d[8*c +: 8] = 8'(c + 1);
        push_beat(16'hFFFF, d, 16, 1, 1'b0);
        d = '0;
        for (int c = 0; c < 4; c++) d[8*c +: 8] = 8'(c + 17);
        push_beat(16'h000F, d, 4, 2, 1'b1);
        for (int k = 0; k < 20; k++) send_chk(8'(k + 1), k == 19);
        check("partial_frame_done", 32'(bus.frame_done), 1);
        tick();
        check("partial_state_idle", 32'(dbg_state), 32'(ENC_IDLE));
        check("partial_in_ready", 32'(bus.in_ready), 0);

        // All-zero row still writes the flag
        pulse_start();
        push_beat(16'h0000, '0, 0, 1, 1'b0);
        for (int c = 0; c < 16; c++) send_chk(8'd0, 1'b0);
        tick();

        // Overflow: ROW_DEPTH rows with valid gaps, then one extra element
        pulse_start();
        d = '0;
        for (int c = 0; c < 16; c += 2) d[8*c +: 8] = 8'(8'h11 + c);
        for (int r = 0; r < ROW_DEPTH; r++) push_beat(16'h5555, d, 8, r + 1, 1'b0);
        for (int k = 0; k < ROW_DEPTH * 16; k++) begin
            if (k % 7 == 3) tick();
            v = (k % 2 == 0) ? 8'(8'h11 + (k % 16)) : 8'd0;
            send_chk(v, 1'b0);
        end
        tick();
        check("ovf_full", 32'(bus.full), 1);
        check("ovf_in_ready", 32'(bus.in_ready), 0);
        check("ovf_state", 32'(dbg_state), 32'(ENC_FULL));
        check("ovf_row_cnt", 32'(bus.row_cnt), 32'(ROW_DEPTH));
        send(8'h77, 1'b0, 5, ok);
        check("ovf_extra_refused", 32'(ok), 0);
        pulse_start();
        check("ovf_start_full", 32'(bus.full), 0);
        check("ovf_start_row_cnt", 32'(bus.row_cnt), 0);
        check("ovf_start_state", 32'(dbg_state), 32'(ENC_GATHER));

        // Abort: 7 elements then start, then a full row
        pulse_start();
        for (int c = 0; c < 7; c++) send_chk(8'(8'h50 + c), 1'b0);
        pulse_start();
        d = '0;
        for (int c = 0; c < 16; c++) d[8*c +: 8] = 8'(8'hA0 + c);
        push_beat(16'hFFFF, d, 16, 1, 1'b0);
        for (int c = 0; c < 16; c++) send_chk(8'(8'hA0 + c), 1'b0);
        check("abort_row_cnt", 32'(bus.row_cnt), 1);

        // Reset mid-row: nothing written, everything back to 0
        pulse_start();
        for (int c = 0; c < 9; c++) send_chk(8'(8'h30 + c), 1'b0);
        reset = 1'b0;
        #1;
        check("mid_rst_flag_strobe", 32'(bus.wr_req_act_flag), 0);
        check("mid_rst_flag_data", 32'(bus.wr_data_act_flag), 0);
        check("mid_rst_row_cnt", 32'(bus.row_cnt), 0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 0);
        check("mid_rst_state", 32'(dbg_state), 32'(ENC_IDLE));
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("post_rst_state", 32'(dbg_state), 32'(ENC_IDLE));

        // Short frame after reset: 0,0,5,0 with last
        pulse_start();
        d = '0;
        d[23:16] = 8'd5;
        push_beat(16'h0004, d, 1, 1, 1'b1);
        send_chk(8'd0, 1'b0);
        send_chk(8'd0, 1'b0);
        send_chk(8'd5, 1'b0);
        send_chk(8'd0, 1'b1);

        repeat (5) tick();
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
